// File: rtl/ddr_port_arbiter_if.sv
// ddr_port_arbiter_if: requester A/B handshakes plus the single memory port.
// The arbiter connects through the slave modport; requesters and the storage
// block sit on the master side.
interface ddr_port_arbiter_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  // Requester A
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;

  // Requester B
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rvalid;

  // Storage block
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_wr_add;
  logic [ADDR_W-1:0] mem_rd_add;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata, a_rvalid,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata, b_rvalid,
    output mem_wr, mem_rd, mem_wr_add, mem_rd_add, mem_data_in,
    input  mem_data_out
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata, a_rvalid,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata, b_rvalid,
    input  mem_wr, mem_rd, mem_wr_add, mem_rd_add, mem_data_in,
    output mem_data_out
  );
endinterface

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: two-port arbiter and sequencer for the 8x8 DDR storage
// block. Serialises A/B reads and writes onto one memory port, strobes the
// memory for one cycle per access and returns read data to its issuer after
// RD_LAT cycles.
// Build option: define DDR_ARB_FIXED_PRIO_EN to give A strict priority on
// every tie (no round-robin pointer; B can starve). Default is round-robin.
module ddr_port_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  ddr_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state;
  logic              owner_b;   // port that owns the access in flight
  logic              op_we;     // access in flight is a write
  logic [2:0]        cnt;       // read latency countdown

  logic              a_ack;
  logic              b_ack;
  logic              a_rvalid;
  logic              b_rvalid;
  logic [DATA_W-1:0] a_rdata;
  logic [DATA_W-1:0] b_rdata;
  logic              mem_wr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_wr_add;
  logic [ADDR_W-1:0] mem_rd_add;
  logic [DATA_W-1:0] mem_data_in;

  logic              any_req;
  logic              grant_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign any_req = bus.a_req | bus.b_req;

`ifdef DDR_ARB_FIXED_PRIO_EN
  // A wins every tie; B only gets through when A is quiet
  always_comb begin
    grant_b = bus.b_req & ~bus.a_req;
  end
`else
  logic ptr_b;  // 1: last grant went to B, so A wins the next tie

  // On a tie grant the port the pointer is not on; a lone requester always wins
  always_comb begin
    grant_b = bus.b_req;
    if (bus.a_req && bus.b_req) begin
      grant_b = ~ptr_b;
    end
  end

  // Pointer follows every grant; reset parks it on B so A wins the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_b <= 1'b1;
    end else if (state == IDLE && any_req) begin
      ptr_b <= grant_b;
    end
  end
`endif

  // Winner's request fields, consumed only on the IDLE -> ISSUE transition
  always_comb begin
    sel_we    = grant_b ? bus.b_we    : bus.a_we;
    sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
    sel_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
  end

  // Sequencer: all outputs are registered, so the strobe, address/data and
  // ack for an access are loaded when leaving IDLE and are visible exactly
  // during the ISSUE cycle; every pulse defaults back to 0 one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner_b     <= 1'b0;
      op_we       <= 1'b0;
      cnt         <= 3'd0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr_add  <= '0;
      mem_rd_add  <= '0;
      mem_data_in <= '0;
    end else begin
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rvalid    <= 1'b0;
      b_rvalid    <= 1'b0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr_add  <= '0;
      mem_rd_add  <= '0;
      mem_data_in <= '0;

      case (state)
        IDLE: begin
          if (any_req) begin
            owner_b <= grant_b;
            op_we   <= sel_we;
            a_ack   <= ~grant_b;
            b_ack   <= grant_b;
            if (sel_we) begin
              mem_wr      <= 1'b1;
              mem_wr_add  <= sel_addr;
              mem_data_in <= sel_wdata;
            end else begin
              mem_rd      <= 1'b1;
              mem_rd_add  <= sel_addr;
            end
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (op_we) begin
            state <= IDLE;
          end else begin
            cnt   <= 3'(RD_LAT);
            state <= WAIT;
          end
        end

        WAIT: begin
          // Last wait cycle is the one in which mem_data_out is valid
          if (cnt == 3'd1) begin
            cnt <= 3'd0;
            if (owner_b) begin
              b_rdata  <= bus.mem_data_out;
              b_rvalid <= 1'b1;
            end else begin
              a_rdata  <= bus.mem_data_out;
              a_rvalid <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_ack       = a_ack;
  assign bus.b_ack       = b_ack;
  assign bus.a_rvalid    = a_rvalid;
  assign bus.b_rvalid    = b_rvalid;
  assign bus.a_rdata     = a_rdata;
  assign bus.b_rdata     = b_rdata;
  assign bus.mem_wr      = mem_wr;
  assign bus.mem_rd      = mem_rd;
  assign bus.mem_wr_add  = mem_wr_add;
  assign bus.mem_rd_add  = mem_rd_add;
  assign bus.mem_data_in = mem_data_in;

endmodule
